instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
Loader-side counterpart of the main control decoder. It accepts instruction fields by class over a valid/ready stream and encodes them into 32-bit MIPS-style words. The opcodes it emits are exactly the ones the decoder recognises. Each encoded word is written into instruction memory at consecutive word addresses starting from a programmable base. The block sits between the test/boot host and the instruction memory write port.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.

Ports:
clk  in  1  system clock
reset  in  1  reset
start  in  1  begin a load session at base_addr; sampled only in IDLE
base_addr  in  ADDR_W  first word address of the session
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle this cycle
in_cls  in  4  class: 0 R, 1 LW, 2 SW, 3 ADDI, 4 BEQ, 5 BVF, 6 BEN, 7 J, 8-15 illegal
in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
in_funct  in  6  R-type function
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
in_last  in  1  marks final bundle of the session
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  encoded instruction
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at session end
err  out  1  sticky error flag; cleared by start or reset
count  out  ADDR_W+1  words written in the current session

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; address pointer 0. A reset mid-session drops any in-flight write (mem_we is 0 in the cycle after reset).
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: on start, load pointer <= base_addr, count <= 0, err <= 0, then go to LOAD.
  - LOAD: in_ready = 1. A handshake (in_valid & in_ready) encodes the bundle into the output register.
  - LOAD -> DRAIN when the accepted bundle has in_last = 1.
  - DRAIN: in_ready = 0, for one cycle, while the last write issues; then DONE.
  - DONE: done = 1 for one cycle; then IDLE.
- start is ignored outside IDLE.
- Latency: a handshake in cycle N gives mem_we = 1 in cycle N+1, with mem_addr = pointer and the encoded mem_wdata. After the write, pointer increments and count increments.
- Throughput: one word per cycle, no bubbles. Back-to-back handshakes produce back-to-back writes.
- Encoding, with opcode in bits [31:26]:
  - R: 0x00 | rs | rt | rd | shamt | funct
  - LW: 0x23; SW: 0x2B; ADDI: 0x08; BEQ: 0x04; BVF: 0x05; BEN: 0x06. These are I-format: op | rs | rt | imm.
  - J: 0x02 | target.
  - Fields not used by a class are ignored.
- Illegal class: the write still occurs with word 0x00000000 (NOP), and err is set.
- Wrap-around: pointer increments modulo DEPTH.
- Capacity: when count == DEPTH, further handshakes are accepted but not written (mem_we = 0), and err is set. in_last still terminates the session normally.
- in_valid while in_ready = 0: ignored; the bundle is not consumed.

Optional Feature:
INSTR_ENC_BRANCH_REL_EN
- Defined: for BEQ/BVF/BEN, in_imm is an absolute word address. The encoder writes offset = in_imm - (pointer + 1), truncated to 16 bits.
- Undefined: in_imm is passed through unchanged for every class.

Decomposition:
- Shared package instr_pkg holds:
  - class enum (CLS_R … CLS_J)
  - opcode constants OP_R=0x00, OP_J=0x02, OP_BEQ=0x04, OP_BVF=0x05, OP_BEN=0x06, OP_ADDI=0x08, OP_LW=0x23, OP_SW=0x2B
  - field bit-position constants
- The decoder imports the same opcode constants.
- Sub-module instr_field_pack: purely combinational class+fields -> 32-bit word plus illegal flag. The top level holds the FSM, pointer, count and output register.

Test Plan:
- start, base_addr = 0x10; R rs=1 rt=2 rd=3 funct=0x20 with in_last -> next cycle mem_we=1, addr 0x10, wdata 0x00221820; DRAIN; done pulse; count=1.
- Back-to-back: LW rs=29 rt=8 imm=4, then J target=0x10 (last) -> writes 0x8FA80004 @0x10 and 0x08000010 @0x11 on consecutive cycles.
- in_cls=9 -> writes 0x00000000; err=1 persists through done; next start clears err.
- base_addr = 0xFF, two words -> writes at 0xFF then 0x00; fill DEPTH+1 words -> extra word not written, err=1.
- Reset asserted the cycle after a handshake -> no mem_we, all outputs 0, FSM IDLE.
- Feature defined: base 0x10, third word BEQ rs=1 rt=2 imm=0x0010 (addr 0x12) -> wdata 0x1022FFFD. Feature undefined -> 0x10220010.

Source files
------------

// File: rtl/instr_stream_encoder_pkg.sv
// Shared instruction-format definitions: class codes, opcodes and field positions.
// The control decoder imports the same opcode constants, so both sides always agree.
package instr_pkg;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_LW   = 4'd1,
        CLS_SW   = 4'd2,
        CLS_ADDI = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_BVF  = 4'd5,
        CLS_BEN  = 4'd6,
        CLS_J    = 4'd7
    } cls_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BVF  = 6'h05;
    localparam logic [5:0] OP_BEN  = 6'h06;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return (32'(OP_R) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
               (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | 32'(funct);
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
    endfunction

    function automatic logic [31:0] pack_j(input logic [25:0] target);
        return (32'(OP_J) << OP_LSB) | 32'(target);
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Field-bundle stream from the host and instruction-memory write port.
// The host drives the master side of instr_stream_if; the encoder drives the master side of imem_wr_if.
interface instr_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cls;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_cls, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, in_last,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_cls, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

interface imem_wr_if #(parameter int ADDR_W = 8);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_stream_encoder_field_pack.sv
// Combinational class + fields -> 32-bit instruction word, flagging unknown classes.
// INSTR_ENC_BRANCH_REL_EN: branch immediates arrive as absolute word addresses and are made PC-relative.
module instr_field_pack
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [3:0]        cls_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [31:0]       word_o,
    output logic              illegal_o
);

    logic [15:0] branchImm;

`ifdef INSTR_ENC_BRANCH_REL_EN
    // Offset is relative to the word after the branch itself.
    assign branchImm = imm_i - (16'(pc_i) + 16'd1);
`else
    logic unusedPc;
    assign unusedPc  = ^pc_i;
    assign branchImm = imm_i;
`endif

    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        case (cls_i)
            CLS_R:    word_o = pack_r(rs_i, rt_i, rd_i, shamt_i, funct_i);
            CLS_LW:   word_o = pack_i(OP_LW, rs_i, rt_i, imm_i);
            CLS_SW:   word_o = pack_i(OP_SW, rs_i, rt_i, imm_i);
            CLS_ADDI: word_o = pack_i(OP_ADDI, rs_i, rt_i, imm_i);
            CLS_BEQ:  word_o = pack_i(OP_BEQ, rs_i, rt_i, branchImm);
            CLS_BVF:  word_o = pack_i(OP_BVF, rs_i, rt_i, branchImm);
            CLS_BEN:  word_o = pack_i(OP_BEN, rs_i, rt_i, branchImm);
            CLS_J:    word_o = pack_j(target_i);
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Session FSM, write pointer, word count and registered memory write port for the loader encoder.
// Optional macro INSTR_ENC_BRANCH_REL_EN is handled inside instr_field_pack.
module instr_stream_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_stream_if.slave     in_if,
    imem_wr_if.master         mem_if,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       packedWord;
    logic              packedIllegal;
    logic              handshake;

    instr_field_pack #(.ADDR_W(ADDR_W)) u_pack (
        .cls_i     (in_if.in_cls),
        .rs_i      (in_if.in_rs),
        .rt_i      (in_if.in_rt),
        .rd_i      (in_if.in_rd),
        .shamt_i   (in_if.in_shamt),
        .funct_i   (in_if.in_funct),
        .imm_i     (in_if.in_imm),
        .target_i  (in_if.in_target),
        .pc_i      (ptr_q),
        .word_o    (packedWord),
        .illegal_o (packedIllegal)
    );

    assign in_if.in_ready = (state_q == S_LOAD);
    assign handshake      = in_if.in_valid & in_if.in_ready;

    // Pointer and count advance at the handshake; the output register carries the word's address.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    if (packedIllegal) err_d = 1'b1;
                    if (count_q == FULL_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = packedWord;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        count_d = count_q + (ADDR_W+1)'(1);
                    end
                    if (in_if.in_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign err              = err_q;
    assign count            = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: expected writes are queued at each handshake
// and checked by a negedge monitor as the memory port fires.
module tb_instr_stream_encoder;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic       busy, done, err;
    logic [8:0] count;

    int   checkCount = 0;
    int   failCount  = 0;
    wr_t  sb[$];
    logic [7:0] expPtr;

    instr_stream_if sif();
    imem_wr_if #(.ADDR_W(8)) mif();

    instr_stream_encoder #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .in_if     (sif),
        .mem_if    (mif),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the instruction format table.
    function automatic logic [31:0] encode(input int cls, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn, input logic [15:0] imm,
                                           input logic [25:0] tgt, input logic [7:0] addr);
        logic [15:0] bImm;
`ifdef INSTR_ENC_BRANCH_REL_EN
        bImm = imm - ({8'h00, addr} + 16'd1);
`else
        bImm = imm;
`endif
        case (cls)
            0: return {6'h00, rs, rt, rd, sh, fn};
            1: return {6'h23, rs, rt, imm};
            2: return {6'h2B, rs, rt, imm};
            3: return {6'h08, rs, rt, imm};
            4: return {6'h04, rs, rt, bImm};
            5: return {6'h05, rs, rt, bImm};
            6: return {6'h06, rs, rt, bImm};
            7: return {6'h02, tgt};
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startSession(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        expPtr    = base;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic applyStimulus(input int cls, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] imm, input logic [25:0] tgt, input bit last,
                                 input logic [31:0] expWord, input bit expWrite);
        int waitCycles = 0;
        sif.in_valid  = 1'b1;
        sif.in_cls    = 4'(cls);
        sif.in_rs     = rs;
        sif.in_rt     = rt;
        sif.in_rd     = rd;
        sif.in_shamt  = sh;
        sif.in_funct  = fn;
        sif.in_imm    = imm;
        sif.in_target = tgt;
        sif.in_last   = last;
        while (!sif.in_ready && waitCycles < 4) begin
            tick();
            waitCycles++;
        end
        checkOutput("in_ready", 32'(sif.in_ready), 32'd1);
        if (expWrite) begin
            sb.push_back('{addr: expPtr, data: expWord});
            expPtr = expPtr + 8'd1;
        end
        tick();
        checkOutput("we_latency", 32'(mif.mem_we), 32'(expWrite));
        if (last) sif.in_valid = 1'b0;
    endtask

    task automatic waitDone(input logic [8:0] expCount, input logic expErr);
        int n = 0;
        while (!done && n < 8) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("count_at_done", 32'(count), 32'(expCount));
        checkOutput("err_at_done", 32'(err), 32'(expErr));
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && mif.mem_we) begin
            checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                checkOutput("wr_addr", 32'(mif.mem_addr), 32'(e.addr));
                checkOutput("wr_data", mif.mem_wdata, e.data);
            end
        end
    end

    initial begin
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        int          cls;
        logic [31:0] brExp;

        reset = 1'b1; start = 1'b0; base_addr = '0; expPtr = '0;
        sif.in_valid = 1'b0; sif.in_cls = '0; sif.in_rs = '0; sif.in_rt = '0; sif.in_rd = '0;
        sif.in_shamt = '0; sif.in_funct = '0; sif.in_imm = '0; sif.in_target = '0; sif.in_last = 1'b0;
        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_we", 32'(mif.mem_we), 32'd0);
        checkOutput("rst_ready", 32'(sif.in_ready), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] single R word at 0x10");
        startSession(8'h10);
        applyStimulus(0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 1'b1);
        checkOutput("drain_ready", 32'(sif.in_ready), 32'd0);
        waitDone(9'd1, 1'b0);

        $display("[TB] back-to-back LW + J, bundle offered during drain is ignored");
        startSession(8'h10);
        applyStimulus(1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0, 32'h8FA8_0004, 1'b1);
        applyStimulus(7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, 32'h0800_0010, 1'b1);
        sif.in_valid = 1'b1;
        sif.in_cls   = 4'd0;
        waitDone(9'd2, 1'b0);
        sif.in_valid = 1'b0;

        $display("[TB] illegal class writes NOP and sets err");
        startSession(8'h20);
        applyStimulus(9, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 32'h0, 1'b1);
        waitDone(9'd1, 1'b1);
        checkOutput("err_sticky_idle", 32'(err), 32'd1);
        startSession(8'hFF);
        checkOutput("err_cleared", 32'(err), 32'd0);

        $display("[TB] wrap from 0xFF to 0x00");
        applyStimulus(0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0, 1'b0,
                      encode(0, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0, 8'hFF), 1'b1);
        applyStimulus(3, 5'd9, 5'd10, 5'd0, 5'd0, 6'h00, 16'h8001, 26'h0, 1'b1,
                      encode(3, 5'd9, 5'd10, 5'd0, 5'd0, 6'h00, 16'h8001, 26'h0, 8'h00), 1'b1);
        waitDone(9'd2, 1'b0);

        $display("[TB] fill beyond capacity");
        startSession(8'h00);
        for (int i = 0; i <= 256; i++) begin
            cls = i % 8;
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
            fn = 6'($urandom); imm = 16'($urandom); tgt = 26'($urandom);
            applyStimulus(cls, rs, rt, rd, sh, fn, imm, tgt, i == 256,
                          encode(cls, rs, rt, rd, sh, fn, imm, tgt, expPtr), i < 256);
            if (i == 255) begin
                checkOutput("full_count", 32'(count), 32'd256);
                checkOutput("full_no_err_yet", 32'(err), 32'd0);
            end
        end
        waitDone(9'd256, 1'b1);

        $display("[TB] branch immediate handling");
`ifdef INSTR_ENC_BRANCH_REL_EN
        brExp = 32'h1022_FFFD;
`else
        brExp = 32'h1022_0010;
`endif
        startSession(8'h10);
        applyStimulus(3, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0, 32'h2021_0005, 1'b1);
        applyStimulus(3, 5'd2, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0006, 26'h0, 1'b0, 32'h2042_0006, 1'b1);
        applyStimulus(4, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b1, brExp, 1'b1);
        waitDone(9'd3, 1'b0);

        $display("[TB] reset right after a handshake");
        startSession(8'h40);
        sif.in_valid = 1'b1; sif.in_cls = 4'd0; sif.in_last = 1'b0;
        tick();
        reset = 1'b1;
        sif.in_valid = 1'b0;
        tick();
        checkOutput("rst_mid_we", 32'(mif.mem_we), 32'd0);
        checkOutput("rst_mid_addr", 32'(mif.mem_addr), 32'd0);
        checkOutput("rst_mid_wdata", mif.mem_wdata, 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_count", 32'(count), 32'd0);
        checkOutput("rst_mid_ready", 32'(sif.in_ready), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
